// File: rtl/serial_clock.sv
// Divides clk by 2*2**DIV_LOG2 to make sclk, with registered one-cycle
// strobes that mark each sclk rising and falling transition.
module serial_clock #(
    parameter int DIV_LOG2 = 2
) (
    input  logic clk,
    output logic sclk,
    output logic sclkPosEdge,
    output logic sclkNegEdge,
    input  logic reset,
    input  logic en
);

    localparam logic [DIV_LOG2-1:0] MAX_COUNT = {DIV_LOG2{1'b1}};

    logic [DIV_LOG2-1:0] count_q, count_d;
    logic                sclk_q, sclk_d;
    logic                pos_q, pos_d;
    logic                neg_q, neg_d;

    // Strobes are computed alongside the toggle so they rise together with sclk.
    always_comb begin
        count_d = count_q;
        sclk_d  = sclk_q;
        pos_d   = 1'b0;
        neg_d   = 1'b0;
        if (en) begin
            count_d = count_q + DIV_LOG2'(1);
            if (count_q == MAX_COUNT) begin
                sclk_d = ~sclk_q;
                pos_d  = ~sclk_q;
                neg_d  = sclk_q;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
            sclk_q  <= 1'b0;
            pos_q   <= 1'b0;
            neg_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            sclk_q  <= sclk_d;
            pos_q   <= pos_d;
            neg_q   <= neg_d;
        end
    end

    assign sclk        = sclk_q;
    assign sclkPosEdge = pos_q;
    assign sclkNegEdge = neg_q;

endmodule

// File: tb/tb_serial_clock.sv
// Scoreboarded bench for serial_clock at DIV_LOG2=2 and DIV_LOG2=1, checked
// against an arithmetic model based on the count of enabled edges since reset.
module tb_serial_clock;

    logic clk = 1'b0;
    logic reset;
    logic en;
    logic sclk2, pos2, neg2;
    logic sclk1, pos1, neg1;

    typedef struct packed {
        logic sclk2, pos2, neg2;
        logic sclk1, pos1, neg1;
    } exp_t;

    exp_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;

    // Reference model state: enabled edges since the last reset, plus held values.
    longint n2 = 0, n1 = 0;
    exp_t   cur = '0;

    serial_clock #(.DIV_LOG2(2)) dut2 (
        .clk(clk), .sclk(sclk2), .sclkPosEdge(pos2), .sclkNegEdge(neg2),
        .reset(reset), .en(en)
    );

    serial_clock #(.DIV_LOG2(1)) dut1 (
        .clk(clk), .sclk(sclk1), .sclkPosEdge(pos1), .sclkNegEdge(neg1),
        .reset(reset), .en(en)
    );

    always #5 clk = ~clk;

    // sclk level after n enabled edges is bit D of n; a transition lands when n is a multiple of 2**D.
    function automatic void model_edge(input logic e, input int d, inout longint n,
                                       inout logic s, output logic p, output logic q);
        longint h;
        h = longint'(1) << d;
        p = 1'b0;
        q = 1'b0;
        if (e) begin
            n = n + 1;
            s = logic'((n / h) % 2);
            if (n % h == 0) begin
                p = s;
                q = ~s;
            end
        end
    endfunction

    task automatic step(input logic en_v, input logic rst_v);
        logic s, p, q;
        @(negedge clk);
        en    = en_v;
        reset = rst_v;
        if (rst_v) begin
            n2  = 0;
            n1  = 0;
            cur = '0;
            #1;
            vectors++;
            if ({sclk2, pos2, neg2, sclk1, pos1, neg1} !== 6'b0) begin
                miscompares++;
                $display("FAIL async_reset t=%0t got=%b want=000000", $time,
                         {sclk2, pos2, neg2, sclk1, pos1, neg1});
            end
        end else begin
            s = cur.sclk2;
            model_edge(en_v, 2, n2, s, p, q);
            cur.sclk2 = s; cur.pos2 = p; cur.neg2 = q;
            s = cur.sclk1;
            model_edge(en_v, 1, n1, s, p, q);
            cur.sclk1 = s; cur.pos1 = p; cur.neg1 = q;
        end
        exp_q.push_back(cur);
    endtask

    // Monitor: each posedge presents a new output vector.
    initial begin
        exp_t e;
        exp_t got;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                got = '{sclk2, pos2, neg2, sclk1, pos1, neg1};
                vectors++;
                if (got !== e) begin
                    miscompares++;
                    $display("FAIL outputs t=%0t got(s2,p2,n2,s1,p1,n1)=%b want=%b",
                             $time, got, e);
                end
            end
        end
    end

    initial begin
        int drain;
        en    = 1'b0;
        reset = 1'b1;
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);

        // Basic timing after release: rises at edge 4, falls at 8, rises at 12.
        repeat (20) step(1'b1, 1'b0);

        // Enable dropped for 5 cycles after edge 2.
        step(1'b1, 1'b1);
        repeat (2) step(1'b1, 1'b0);
        repeat (5) step(1'b0, 1'b0);
        repeat (12) step(1'b1, 1'b0);

        // Async reset in the middle of the high phase (between edges 5 and 6).
        step(1'b1, 1'b1);
        repeat (5) step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        repeat (16) step(1'b1, 1'b0);

        // Free run.
        repeat (100) step(1'b1, 1'b0);

        // Randomized enable with occasional resets.
        repeat (400) step(($urandom % 4) != 0, ($urandom % 50) == 0);

        drain = 0;
        while (exp_q.size() > 0 && drain < 20) begin
            @(posedge clk);
            drain++;
        end
        #2;
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain pending=%0d want=0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
